// File: rtl/instruction_bus_responder_pkg.sv
// Shared types and helpers for the instruction fetch responder.
// Covers the bus word, the fetch FSM states and the window check.
package instruction_bus_responder_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQUEST = 2'd1,
    WAIT    = 2'd2,
    FAULT   = 2'd3
  } fetch_bus_state_t;

  localparam word_t INSTRUCTION_NOP = 32'h0000_0000;

  // 33-bit compare so a window ending at 2^32 does not wrap to zero.
  function automatic logic in_window(word_t addr, word_t base, word_t bytes);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = lo + {1'b0, bytes};
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/instruction_bus_responder_if.sv
// Instruction memory port: request/accept handshake plus response channel.
// The master modport belongs to the responder; the slave modport belongs to the memory.
interface instruction_bus_responder_if;
  import instruction_bus_responder_pkg::*;

  word_t memAddress;
  logic  memRequest;
  logic  memAccept;
  logic  memValid;
  word_t memData;
  logic  memError;

  modport master (
    output memAddress, memRequest,
    input  memAccept, memValid, memData, memError
  );

  modport slave (
    input  memAddress, memRequest,
    output memAccept, memValid, memData, memError
  );

endinterface

// File: rtl/instruction_bus_responder_timeout_counter.sv
// Counts cycles spent waiting for a memory response.
// o_terminal flags the cycle in which the count reaches TIMEOUT_CYCLES.
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_terminal
);

  localparam logic [7:0] LIMIT    = 8'(TIMEOUT_CYCLES);
  localparam logic [7:0] TERMINAL = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_terminal = i_enable && (r_count == TERMINAL);

endmodule

// File: rtl/instruction_bus_responder.sv
// Fetch-side responder: one-entry holding register in front of the instruction memory.
// Hits are combinational; misses stall the fetch stage until the fill or a fault.
module instruction_bus_responder
  import instruction_bus_responder_pkg::*;
#(
  parameter word_t BASE_ADDRESS   = 32'h0000_0000,
  parameter word_t WINDOW_BYTES   = 32'h0001_0000,
  parameter int    TIMEOUT_CYCLES = 16
) (
  input  logic  clk,
  input  logic  reset,
  input  word_t programCounter,
  input  logic  invalidate,
  output word_t instruction,
  output logic  stall,
  output logic  busFault,
  instruction_bus_responder_if.master mem
);

  fetch_bus_state_t r_state;
  fetch_bus_state_t w_state_next;
  logic             r_tag_valid;
  word_t            r_tag;
  word_t            r_data;

  logic w_hit;
  logic w_addr_ok;
  logic w_fill;
  logic w_timeout;

  assign w_hit     = r_tag_valid && !invalidate && (r_tag == programCounter);
  assign w_addr_ok = in_window(programCounter, BASE_ADDRESS, WINDOW_BYTES) &&
                     (programCounter[1:0] == 2'b00);

  bus_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (r_state != WAIT),
    .i_enable  (r_state == WAIT),
    .o_terminal(w_timeout)
  );

  always_comb begin
    w_state_next    = r_state;
    w_fill          = 1'b0;
    stall           = 1'b0;
    busFault        = 1'b0;
    instruction     = INSTRUCTION_NOP;
    mem.memRequest  = 1'b0;
    mem.memAddress  = {programCounter[31:2], 2'b00};
    case (r_state)
      IDLE: begin
        if (w_hit) begin
          instruction = r_data;
        end else if (!w_addr_ok) begin
          stall        = 1'b1;
          w_state_next = FAULT;
        end else begin
          stall          = 1'b1;
          mem.memRequest = 1'b1;
          w_state_next   = mem.memAccept ? WAIT : REQUEST;
        end
      end
      REQUEST: begin
        stall          = 1'b1;
        mem.memRequest = 1'b1;
        if (mem.memAccept) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        // A response in the final counted cycle still wins over the timeout.
        if (mem.memValid) begin
          if (mem.memError) begin
            w_state_next = FAULT;
          end else begin
            w_fill       = 1'b1;
            w_state_next = IDLE;
          end
        end else if (w_timeout) begin
          w_state_next = FAULT;
        end
      end
      FAULT: begin
        busFault     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tag_valid <= 1'b0;
      r_tag       <= '0;
      r_data      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_fill) begin
        r_tag_valid <= 1'b1;
        r_tag       <= programCounter;
        r_data      <= mem.memData;
      end else if (invalidate) begin
        r_tag_valid <= 1'b0;
      end
    end
  end

endmodule
